// File: rtl/cvtws_round_seq.sv
// -----------------------------------------------------------------------------
// cvtws_round_seq
//   Sequential float-to-signed-integer converter. One {sign,exp,frac} operand is
//   accepted per valid/ready transaction. The significand is aligned by shifting
//   right SHIFT_STEP bits per cycle, collecting guard and sticky bits. The value
//   is then rounded with a one-hot rounding-mode vector and saturated to INTn
//   bits. Only one operation is in flight at a time.
//
//   FSM: IDLE -> PREP -> SHIFT (x N) -> ROUND -> HOLD -> IDLE
//   out_valid rises N+2 cycles after the accepting clock edge.
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are both
//   high. in_ready is high only in IDLE. The producer holds a/ra stable while
//   in_valid is high and not yet accepted. out_valid stays high with result/flags
//   stable until out_ready is seen.
//
// Ports
//   clk        in   1             clock
//   rst        in   1             synchronous active-high reset
//   in_valid   in   1             operand valid
//   in_ready   out  1             high only in IDLE
//   a          in   NEXP+NSIG+1   {sign, exp, frac}
//   ra         in   LAST_RA+1     rounding mode (one-hot), sampled at accept:
//                                 0 TiesToEven, 1 TowardZero, 2 TowardPositive,
//                                 3 TowardNegative, 4 TiesToAway
//   out_valid  out  1             result valid, held until taken
//   out_ready  in   1             consumer accepts result
//   result     out  INTn          two's-complement result
//   flags      out  2             {invalid, inexact}
//   dbg_state  out  3             current FSM state (debug visibility)
//
// Configuration macro
//   FPU_CVTWS_FLAGS_EN : when defined, flags are computed; otherwise flags is
//                        tied to 2'b00 and no flag logic exists. result and
//                        timing are identical in both builds.
// -----------------------------------------------------------------------------
module cvtws_round_seq #(
  parameter int INTn       = 32,
  parameter int NEXP       = 8,
  parameter int NSIG       = 23,
  parameter int LAST_RA    = 4,
  parameter int SHIFT_STEP = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NEXP+NSIG:0]   a,
  input  logic [LAST_RA:0]     ra,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INTn-1:0]      result,
  output logic [1:0]           flags,
  output logic [2:0]           dbg_state
);

  localparam int BIAS = (1 << (NEXP-1)) - 1;
  localparam int MW   = INTn + 1;               // room for the rounding carry
  localparam int RW   = $clog2(NSIG+3) + 1;     // remaining right-shift count
  localparam int LW   = $clog2(INTn) + 1;       // left-shift count

  localparam logic [MW-1:0]   MAX_POS = {2'b00, {(INTn-1){1'b1}}};
  localparam logic [MW-1:0]   MAX_NEG = {2'b01, {(INTn-1){1'b0}}};
  localparam logic [INTn-1:0] SAT_POS = {1'b0, {(INTn-1){1'b1}}};
  localparam logic [INTn-1:0] SAT_NEG = {1'b1, {(INTn-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PREP  = 3'd1,
    S_SHIFT = 3'd2,
    S_ROUND = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [NEXP-1:0]   exp_q, exp_d;
  logic [NSIG-1:0]   frac_q, frac_d;
  logic [LAST_RA:0]  ra_q, ra_d;
  logic [MW-1:0]     mag_q, mag_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [LW-1:0]     lsh_q, lsh_d;
  logic              sat_q, sat_d;
  logic              sat_neg_q, sat_neg_d;
  logic [INTn-1:0]   result_q, result_d;
`ifdef FPU_CVTWS_FLAGS_EN
  logic              sat_inv_q, sat_inv_d;
  logic [1:0]        flags_q, flags_d;
`endif

  // Combinational helpers
  int                e_i, s_i;
  logic [RW-1:0]     amt;
  logic [MW-1:0]     sh_out, low_mask, mag_l, mag_r;
  logic              rb, gs, ovf, neg_sat;

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_HOLD);
  assign result    = result_q;
  assign dbg_state = state_q;
`ifdef FPU_CVTWS_FLAGS_EN
  assign flags     = flags_q;
`else
  assign flags     = 2'b00;
`endif

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    frac_d    = frac_q;
    ra_d      = ra_q;
    mag_d     = mag_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    rem_d     = rem_q;
    lsh_d     = lsh_q;
    sat_d     = sat_q;
    sat_neg_d = sat_neg_q;
    result_d  = result_q;
`ifdef FPU_CVTWS_FLAGS_EN
    sat_inv_d = sat_inv_q;
    flags_d   = flags_q;
`endif

    // Unbiased exponent and the right-shift distance that puts the binary
    // point just below bit 0.
    e_i = int'(exp_q) - BIAS;
    s_i = NSIG - e_i;

    // SHIFT step: the last step shifts whatever remains.
    amt      = (rem_q > RW'(SHIFT_STEP)) ? RW'(SHIFT_STEP) : rem_q;
    sh_out   = mag_q >> (amt - RW'(1));
    low_mask = (MW'(1) << (amt - RW'(1))) - MW'(1);

    // ROUND: round-up bit is the OR of each selected mode's term.
    mag_l = mag_q << lsh_q;
    gs    = guard_q | sticky_q;
    rb    = (ra_q[0] & guard_q & (mag_l[0] | sticky_q))   // ties to even
          | (ra_q[1] & 1'b0)                              // toward zero: no term
          | (ra_q[2] & ~sign_q & gs)                      // toward +inf
          | (ra_q[3] &  sign_q & gs)                      // toward -inf
          | (ra_q[4] & guard_q);                          // ties to away
    mag_r   = mag_l + MW'(rb);
    ovf     = sign_q ? (mag_r > MAX_NEG) : (mag_r > MAX_POS);
    neg_sat = sat_q ? sat_neg_q : sign_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d  = a[NEXP+NSIG];
          exp_d   = a[NEXP+NSIG-1:NSIG];
          frac_d  = a[NSIG-1:0];
          ra_d    = ra;
          state_d = S_PREP;
        end
      end

      S_PREP: begin
        mag_d     = MW'({1'b1, frac_q});
        guard_d   = 1'b0;
        sticky_d  = 1'b0;
        rem_d     = '0;
        lsh_d     = '0;
        sat_d     = 1'b0;
        sat_neg_d = 1'b0;
`ifdef FPU_CVTWS_FLAGS_EN
        sat_inv_d = 1'b0;
`endif
        state_d   = S_ROUND;
        if (exp_q == {NEXP{1'b1}}) begin
          // NaN saturates positive; Inf saturates toward its sign.
          sat_d     = 1'b1;
          sat_neg_d = sign_q & (frac_q == '0);
`ifdef FPU_CVTWS_FLAGS_EN
          sat_inv_d = 1'b1;
`endif
        end else if (exp_q == '0) begin
          // Zero / subnormal: no integer part, only a sticky contribution.
          mag_d    = '0;
          sticky_d = |frac_q;
        end else if (e_i >= INTn-1 &&
                     !(sign_q && e_i == INTn-1 && frac_q == '0)) begin
          // Too large. -2^(INTn-1) itself is exact and falls through to the
          // left-shift path below via the else-if chain not firing here.
          sat_d     = 1'b1;
          sat_neg_d = sign_q;
`ifdef FPU_CVTWS_FLAGS_EN
          sat_inv_d = 1'b1;
`endif
        end else if (s_i <= 0) begin
          lsh_d = LW'(-s_i);
        end else if (s_i > NSIG+2) begin
          // Everything shifts out below the guard position.
          mag_d    = '0;
          sticky_d = 1'b1;
        end else begin
          rem_d   = RW'(s_i);
          state_d = S_SHIFT;
        end
      end

      S_SHIFT: begin
        mag_d    = mag_q >> amt;
        guard_d  = sh_out[0];
        // Previous guard and all bits below the new guard become sticky.
        sticky_d = sticky_q | guard_q | (|(mag_q & low_mask));
        rem_d    = rem_q - amt;
        if (rem_q == amt) state_d = S_ROUND;
      end

      S_ROUND: begin
        if (sat_q || ovf) begin
          result_d = neg_sat ? SAT_NEG : SAT_POS;
        end else if (sign_q) begin
          result_d = ~mag_r[INTn-1:0] + INTn'(1);
        end else begin
          result_d = mag_r[INTn-1:0];
        end
`ifdef FPU_CVTWS_FLAGS_EN
        begin
          logic inv;
          inv     = sat_q ? sat_inv_q : ovf;
          flags_d = {inv, gs & ~inv};
        end
`endif
        state_d = S_HOLD;
      end

      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      frac_q    <= '0;
      ra_q      <= '0;
      mag_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      rem_q     <= '0;
      lsh_q     <= '0;
      sat_q     <= 1'b0;
      sat_neg_q <= 1'b0;
      result_q  <= '0;
`ifdef FPU_CVTWS_FLAGS_EN
      sat_inv_q <= 1'b0;
      flags_q   <= 2'b00;
`endif
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      frac_q    <= frac_d;
      ra_q      <= ra_d;
      mag_q     <= mag_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      rem_q     <= rem_d;
      lsh_q     <= lsh_d;
      sat_q     <= sat_d;
      sat_neg_q <= sat_neg_d;
      result_q  <= result_d;
`ifdef FPU_CVTWS_FLAGS_EN
      sat_inv_q <= sat_inv_d;
      flags_q   <= flags_d;
`endif
    end
  end

endmodule
